// File: rtl/instr_mem_sync.sv
// Instruction memory with program-load port and a single-outstanding fetch
// interface; responses appear a fixed RD_LAT cycles after acceptance.
module instr_mem_sync #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  input  logic              load_en,
  input  logic [63:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fault_q, fault_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic          req_fault;
  logic          load_ok;
  logic          mem_we;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] load_idx;

  always_comb begin
    req_idx   = req_addr[AW+1:2];
    load_idx  = load_addr[AW+1:2];
    // Any set bit above the word index means the byte address is >= 4*DEPTH
    req_fault = (req_addr[1:0] != 2'b00) || (req_addr[63:AW+2] != '0);
    load_ok   = (load_addr[1:0] == 2'b00) && (load_addr[63:AW+2] == '0);
    req_ready = (state_q == IDLE) && !load_en;
    mem_we    = (state_q == IDLE) && load_en && load_ok;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !load_en) begin
          fault_d = req_fault;
          data_d  = req_fault ? '0 : mem[req_idx];
          cnt_d   = LAT_INIT;
          state_d = (RD_LAT > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          data_d  = '0;
          fault_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        data_d  = '0;
        fault_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  // Program contents deliberately survive reset
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[load_idx] <= load_data;
    end
  end

  always_comb begin
    rsp_valid = (state_q == RESP);
    rsp_data  = rsp_valid ? data_q : '0;
    rsp_fault = rsp_valid && fault_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: directed literal cases, a latency
// sweep on two extra instances, and randomized traffic against a word-level model.
module tb_instr_mem_sync;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        resetl;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, load_en, busy;
  logic [63:0] req_addr, load_addr;
  logic [31:0] rsp_data, load_data;

  instr_mem_sync #(.DEPTH(DEPTH), .DATA_W(32), .RD_LAT(LAT)) dut (
    .CLK(CLK), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
  );

  // Latency sweep instances share one set of inputs
  logic        s_req_valid, s_rsp_ready, s_load_en;
  logic [63:0] s_req_addr, s_load_addr;
  logic [31:0] s_load_data;
  logic        a_req_ready, a_rsp_valid, a_rsp_fault, a_busy;
  logic        b_req_ready, b_rsp_valid, b_rsp_fault, b_busy;
  logic [31:0] a_rsp_data, b_rsp_data;

  instr_mem_sync #(.DEPTH(16), .DATA_W(32), .RD_LAT(1)) dut_l1 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(s_req_valid), .req_ready(a_req_ready), .req_addr(s_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(a_rsp_data), .rsp_fault(a_rsp_fault),
    .load_en(s_load_en), .load_addr(s_load_addr), .load_data(s_load_data), .busy(a_busy)
  );

  instr_mem_sync #(.DEPTH(16), .DATA_W(32), .RD_LAT(15)) dut_l15 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(s_req_valid), .req_ready(b_req_ready), .req_addr(s_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(b_rsp_data), .rsp_fault(b_rsp_fault),
    .load_en(s_load_en), .load_addr(s_load_addr), .load_data(s_load_data), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit bad_addr(input logic [63:0] a);
    return (a[1:0] != 2'b00) || (a >= 64'(4 * DEPTH));
  endfunction

  // Word-level reference: one outstanding fetch, aged in clock edges
  logic [31:0] mmem [DEPTH];
  bit          outst = 1'b0;
  int          age   = 0;
  logic [31:0] m_data = '0;
  bit          m_fault = 1'b0;
  bit          m_v;

  always @(negedge CLK) begin
    if (!resetl) outst = 1'b0;
    m_v = outst && (age >= int'(LAT));
    chk("req_ready", req_ready, !outst && !load_en);
    chk("rsp_valid", rsp_valid, m_v);
    chk("rsp_data",  rsp_data,  m_v ? m_data : 32'h0);
    chk("rsp_fault", rsp_fault, m_v && m_fault);
    chk("busy",      busy,      outst);
    if (resetl) begin
      if (outst) begin
        if (m_v && rsp_ready) outst = 1'b0;
        else age++;
      end else if (load_en) begin
        if (!bad_addr(load_addr)) mmem[load_addr[9:2]] = load_data;
      end else if (req_valid) begin
        outst   = 1'b1;
        age     = 1;
        m_fault = bad_addr(req_addr);
        m_data  = m_fault ? 32'h0 : mmem[req_addr[9:2]];
      end
    end
  end

  task automatic do_load(input logic [63:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic fetch_lit(input logic [63:0] a, input logic [31:0] ed, input bit ef, input string nm);
    int n;
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    #1 chk({nm, "_accept"}, req_ready, 1'b1);
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk({nm, "_lat"},   64'(n + 1), 64'(LAT));
    chk({nm, "_data"},  rsp_data, ed);
    chk({nm, "_fault"}, rsp_fault, ef);
    step();
    chk({nm, "_ready_after"}, req_ready, 1'b1);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 64'($urandom_range(0, 4 * DEPTH - 1)) | 64'($urandom_range(1, 3));
    if (r == 1) return 64'(4 * DEPTH + 4 * $urandom_range(0, 255));
    if (r == 2) return ({$urandom, $urandom} & ~64'h3) | 64'h1_0000_0000;
    return 64'(4 * $urandom_range(0, DEPTH - 1));
  endfunction

  initial begin
    int n, n1, n15;
    resetl = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; load_en = 1'b0;
    req_addr = '0; load_addr = '0; load_data = '0;
    s_req_valid = 1'b0; s_rsp_ready = 1'b1; s_load_en = 1'b0;
    s_req_addr = '0; s_load_addr = '0; s_load_data = '0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy",      busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data",  rsp_data, 32'h0);
    chk("rst_rsp_fault", rsp_fault, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    @(posedge CLK); #1 resetl = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) do_load(64'(4 * i), $urandom);

    do_load(64'h0, 32'hF840_03E9);
    do_load(64'h4, 32'h8B09_01AD);
    fetch_lit(64'h4, 32'h8B09_01AD, 1'b0, "fetch4");
    fetch_lit(64'h6, 32'h0, 1'b1, "misaligned");
    fetch_lit(64'(4 * DEPTH), 32'h0, 1'b1, "out_of_range");

    // Back-pressure with a second request waiting
    req_valid = 1'b1; req_addr = 64'h4; rsp_ready = 1'b0;
    step();
    req_addr = 64'h0;
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk("bp_lat", 64'(n + 1), 64'(LAT));
    repeat (5) begin
      step();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data",  rsp_data, 32'h8B09_01AD);
      chk("bp_req_ready",  req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_idle_ready", req_ready, 1'b1);
    chk("bp_idle_busy",  busy, 1'b0);
    step();
    req_valid = 1'b0;
    chk("bp_second_accepted", busy, 1'b1);
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk("bp_second_data", rsp_data, 32'hF840_03E9);
    step();

    // Load and request together: load wins
    load_en = 1'b1; load_addr = 64'h28; load_data = 32'h17FF_FFFD;
    req_valid = 1'b1; req_addr = 64'h28;
    #1 chk("collide_ready", req_ready, 1'b0);
    step();
    load_en = 1'b0;
    chk("collide_not_accepted", busy, 1'b0);
    fetch_lit(64'h28, 32'h17FF_FFFD, 1'b0, "collide_fetch");

    // Reset while waiting discards the pending response
    req_valid = 1'b1; req_addr = 64'h28;
    step();
    req_valid = 1'b0;
    chk("rstw_busy_before", busy, 1'b1);
    resetl = 1'b0;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_rsp_valid", rsp_valid, 1'b0);
    step(); step();
    resetl = 1'b1;
    repeat (4) begin step(); chk("rstw_no_rsp", rsp_valid, 1'b0); end
    fetch_lit(64'h4,  32'h8B09_01AD, 1'b0, "after_rst4");
    fetch_lit(64'h28, 32'h17FF_FFFD, 1'b0, "after_rst28");

    // Latency sweep
    s_load_en = 1'b1; s_load_addr = 64'h8; s_load_data = 32'hA5C3_0F1E;
    step();
    s_load_en = 1'b0;
    s_req_valid = 1'b1; s_req_addr = 64'h8;
    step();
    s_req_valid = 1'b0;
    n1 = -1; n15 = -1;
    for (int k = 0; k < 40; k++) begin
      if (n1 < 0 && a_rsp_valid) begin n1 = k + 1; chk("lat1_data", a_rsp_data, 32'hA5C3_0F1E); end
      if (n15 < 0 && b_rsp_valid) begin n15 = k + 1; chk("lat15_data", b_rsp_data, 32'hA5C3_0F1E); end
      step();
    end
    chk("lat1",  64'(n1), 64'd1);
    chk("lat15", 64'(n15), 64'd15);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = rand_addr();
      load_data = $urandom;
      req_valid = $urandom_range(0, 1);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
